fb_span_writer: RTL
===================

FB_SPAN_WRITER -- requirements
Module: fb_span_writer

Interface
REQ-001 Parameters SHALL be: WORDS_PER_ROW, default 40, 32-bit words per framebuffer row (1280 px); ROWS, default 480, visible rows.
REQ-002 Ports SHALL be, as name  direction  width  meaning:
- clk  in  1  sole clock.
- reset  in  1  synchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_row  in  9  first row.
- cmd_nrows  in  9  row count.
- cmd_word  in  6  first word column.
- cmd_nwords  in  6  words per row.
- cmd_pattern  in  32  word data.
- abort  in  1  cancel the active command.
- address  out  15  framebuffer word address.
- writedata  out  32  word data.
- write  out  1  write strobe.
- chipselect  out  1  equals write.
- busy  out  1  command active.
- done  out  1  one-cycle completion or abort pulse.

Function
REQ-003 The block SHALL be an initiator of framebuffer word writes: one write per asserted clock; the target has no backpressure.
REQ-004 States SHALL be IDLE, WRITE, DONE. IDLE->WRITE on cmd_valid&&cmd_ready with effective writes>0; IDLE->DONE if effective writes==0; WRITE->DONE after the last write or on abort; DONE->IDLE unconditionally.
REQ-005 cmd_ready SHALL be high only in IDLE; command fields SHALL be registered on acceptance and ignored otherwise.
REQ-006 The first write SHALL be asserted the cycle after acceptance, with exactly one write per cycle until complete; there SHALL be no gaps.
REQ-007 Write order SHALL be row-major, words ascending within each row.
REQ-008 address SHALL equal row*WORDS_PER_ROW+word, computed incrementally with a row base advancing by WORDS_PER_ROW and no multiplier.
REQ-009 Rows SHALL be clipped to cmd_row..min(cmd_row+cmd_nrows,ROWS)-1.
REQ-010 Words SHALL be clipped to cmd_word..min(cmd_word+cmd_nwords,WORDS_PER_ROW)-1.
REQ-011 A command with cmd_row>=ROWS, cmd_word>=WORDS_PER_ROW, or a zero count SHALL produce no writes and a done pulse 1 cycle after acceptance.
REQ-012 done SHALL pulse for exactly one cycle, in the DONE state, the cycle after the final write or after abort.
REQ-013 busy SHALL be high in WRITE and DONE.
REQ-014 abort in WRITE SHALL deassert write in that same cycle; the write on that cycle SHALL NOT be issued. abort in IDLE SHALL be ignored.
REQ-015 write, chipselect, address and writedata SHALL be registered outputs. address and writedata SHALL hold their last value when write is low.

Reset
REQ-016 With reset low at a clk edge, the following SHALL take these values: state IDLE, cmd_ready 1 after release, write 0, chipselect 0, busy 0, done 0, address 0, writedata 0.
REQ-017 Reset mid-command SHALL discard the command without a done pulse.

Configuration
REQ-018 With CHECKER_EN defined, writedata SHALL invert on each successive word within a row.
REQ-019 With CHECKER_EN defined, each row SHALL start with cmd_pattern if (row-cmd_row) is even, else ~cmd_pattern.
REQ-020 With CHECKER_EN undefined, writedata SHALL equal cmd_pattern for every write, and no toggle logic SHALL exist.

Structure
REQ-021 Package fb_pkg SHALL hold WORDS_PER_ROW, ROWS, FB_ADDR_W=15, state enum fb_wr_state_t, and struct fb_cmd_t.
REQ-022 Sub-module fb_addr_gen SHALL own the row/word counters, row-base accumulator, clipping, and a last-write flag.

Verification
REQ-023 Scenario 1: row 0, nrows 480, word 0, nwords 40, pattern FFFFFFFF -> 19200 consecutive writes, address 0..19199, done at cycle 19201.
REQ-024 Scenario 2: row 40, nrows 1, word 0, nwords 40, pattern 0000FFFF -> addresses 1600..1639, then done.
REQ-025 Scenario 3: row 478, nrows 5, word 38, nwords 10 -> 4 writes at 19158, 19159, 19198, 19199.
REQ-026 Scenario 4: row 480, nrows 3 -> zero writes, done 1 cycle after acceptance.
REQ-027 Scenario 5: with CHECKER_EN, row 0, nrows 2, word 0, nwords 2, pattern 55555555 -> 55555555, AAAAAAAA, AAAAAAAA, 55555555.
REQ-028 Scenario 6: abort asserted on the 3rd write cycle of a 40-word command -> exactly 2 writes, then done, then cmd_ready; reset mid-command -> no done pulse.

Source files
------------

// File: rtl/fb_pkg.sv
// fb_pkg: shared definitions for the framebuffer span writer.
//   WORDS_PER_ROW / ROWS : default framebuffer geometry (32-bit words, rows)
//   FB_ADDR_W            : framebuffer word-address width
//   fb_wr_state_t        : writer FSM states
//   fb_cmd_t             : span geometry of one fill command
//   row_to_base()        : row * words_per_row built from shifts and adds
package fb_pkg;

  localparam int WORDS_PER_ROW = 40;
  localparam int ROWS          = 480;
  localparam int FB_ADDR_W     = 15;
  localparam int ROW_W         = 9;
  localparam int WORD_W        = 6;
  localparam int DATA_W        = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } fb_wr_state_t;

  typedef struct packed {
    logic [ROW_W-1:0]  row;
    logic [ROW_W-1:0]  nrows;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] nwords;
  } fb_cmd_t;

  // Starting row base for a command. The row width is a constant, so the
  // product reduces to a sum of shifted copies of the row number.
  function automatic logic [FB_ADDR_W-1:0] row_to_base(input logic [ROW_W-1:0] row,
                                                       input int wpr);
    logic [FB_ADDR_W-1:0] acc;
    logic [FB_ADDR_W-1:0] row_ext;
    acc     = '0;
    row_ext = FB_ADDR_W'(row);
    for (int i = 0; i < FB_ADDR_W; i++) begin
      if (wpr[i]) acc = acc + (row_ext << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// fb_addr_gen: row/word walker for one span command.
//   clk, reset  : clock, synchronous active-low reset
//   load        : latch the clipped span described by cmd
//   advance     : step to the next word (row-major, ascending words)
//   cmd         : live command geometry, sampled on load
//   empty       : cmd (live) clips down to zero writes
//   address     : registered word address of the current write
//   last        : the current write is the final one of the span
//   row_wrap    : (CHECKER_EN only) the next step starts a new row
module fb_addr_gen #(
  parameter int WORDS_PER_ROW = 40,
  parameter int ROWS          = 480
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              advance,
  input  fb_pkg::fb_cmd_t   cmd,
  output logic              empty,
  output logic [14:0]       address,
  output logic              last
`ifdef CHECKER_EN
  , output logic            row_wrap
`endif
);
  import fb_pkg::*;

  localparam logic [ROW_W:0]     ROWS_L = (ROW_W+1)'(ROWS);
  localparam logic [WORD_W:0]    WPR_L  = (WORD_W+1)'(WORDS_PER_ROW);
  localparam logic [FB_ADDR_W-1:0] WPR_A = FB_ADDR_W'(WORDS_PER_ROW);

  logic [ROW_W-1:0]     row_reg;
  logic [ROW_W:0]       row_end_reg;     // exclusive, already clipped
  logic [WORD_W-1:0]    word_reg;
  logic [WORD_W-1:0]    word_start_reg;
  logic [WORD_W:0]      word_end_reg;    // exclusive, already clipped
  logic [FB_ADDR_W-1:0] row_base_reg;
  logic [FB_ADDR_W-1:0] address_reg;

  logic [ROW_W:0]       row_end_raw;
  logic [ROW_W:0]       row_end_clip;
  logic [WORD_W:0]      word_end_raw;
  logic [WORD_W:0]      word_end_clip;
  logic [ROW_W:0]       row_next;
  logic [WORD_W:0]      word_next;
  logic                 row_done;
  logic [FB_ADDR_W-1:0] base_start;
  logic [FB_ADDR_W-1:0] base_next;

  always_comb begin
    row_end_raw   = {1'b0, cmd.row} + {1'b0, cmd.nrows};
    row_end_clip  = (row_end_raw > ROWS_L) ? ROWS_L : row_end_raw;
    word_end_raw  = {1'b0, cmd.word} + {1'b0, cmd.nwords};
    word_end_clip = (word_end_raw > WPR_L) ? WPR_L : word_end_raw;
    empty = ({1'b0, cmd.row} >= ROWS_L) || ({1'b0, cmd.word} >= WPR_L) ||
            (cmd.nrows == '0) || (cmd.nwords == '0);
    base_start = row_to_base(cmd.row, WORDS_PER_ROW);

    row_next  = {1'b0, row_reg} + 1'b1;
    word_next = {1'b0, word_reg} + 1'b1;
    row_done  = (word_next == word_end_reg);
    last      = row_done && (row_next == row_end_reg);
    base_next = row_base_reg + WPR_A;
  end

`ifdef CHECKER_EN
  assign row_wrap = row_done;
`endif

  assign address = address_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      row_reg        <= '0;
      row_end_reg    <= '0;
      word_reg       <= '0;
      word_start_reg <= '0;
      word_end_reg   <= '0;
      row_base_reg   <= '0;
      address_reg    <= '0;
    end else if (load) begin
      row_reg        <= cmd.row;
      row_end_reg    <= row_end_clip;
      word_reg       <= cmd.word;
      word_start_reg <= cmd.word;
      word_end_reg   <= word_end_clip;
      row_base_reg   <= base_start;
      address_reg    <= base_start + FB_ADDR_W'(cmd.word);
    end else if (advance) begin
      if (row_done) begin
        // Wrap to the first clipped word of the next row.
        word_reg     <= word_start_reg;
        row_reg      <= row_next[ROW_W-1:0];
        row_base_reg <= base_next;
        address_reg  <= base_next + FB_ADDR_W'(word_start_reg);
      end else begin
        word_reg    <= word_next[WORD_W-1:0];
        address_reg <= address_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_span_writer.sv
// fb_span_writer: fills a clipped rectangle of the framebuffer with a
// pattern, one word write per clock, row-major.
//   clk, reset             : clock, synchronous active-low reset
//   cmd_valid / cmd_ready  : command handshake (ready only when idle)
//   cmd_row, cmd_nrows     : first row and row count
//   cmd_word, cmd_nwords   : first word column and words per row
//   cmd_pattern            : fill data
//   abort                  : cancel the active command (suppresses the
//                            write presented in the same cycle)
//   address, writedata     : registered write address/data (hold when idle)
//   write, chipselect      : write strobe (chipselect mirrors write)
//   busy                   : command in progress
//   done                   : one-cycle completion/abort pulse
// Build option: define CHECKER_EN to alternate the pattern word by word,
// with odd rows of the span starting from the inverted pattern.
module fb_span_writer #(
  parameter int WORDS_PER_ROW = fb_pkg::WORDS_PER_ROW,
  parameter int ROWS          = fb_pkg::ROWS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_row,
  input  logic [8:0]  cmd_nrows,
  input  logic [5:0]  cmd_word,
  input  logic [5:0]  cmd_nwords,
  input  logic [31:0] cmd_pattern,
  input  logic        abort,
  output logic [14:0] address,
  output logic [31:0] writedata,
  output logic        write,
  output logic        chipselect,
  output logic        busy,
  output logic        done
);
  import fb_pkg::*;

  fb_wr_state_t state_reg;
  fb_wr_state_t state_next;

  fb_cmd_t      cmd_in;
  logic         empty;
  logic         last;
  logic         load;
  logic         advance;
  logic [31:0]  writedata_reg;
`ifdef CHECKER_EN
  logic         row_wrap;
  logic [31:0]  row_start_reg;   // data of the first word of the current row
`endif

  assign cmd_in = '{row: cmd_row, nrows: cmd_nrows, word: cmd_word, nwords: cmd_nwords};

  fb_addr_gen #(
    .WORDS_PER_ROW (WORDS_PER_ROW),
    .ROWS          (ROWS)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .advance  (advance),
    .cmd      (cmd_in),
    .empty    (empty),
    .address  (address),
    .last     (last)
`ifdef CHECKER_EN
    , .row_wrap (row_wrap)
`endif
  );

  always_ff @(posedge clk) begin
    if (!reset) state_reg <= S_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    advance    = 1'b0;
    // The strobe is the registered WRITE state, masked by abort so that a
    // cancelled cycle never reaches the framebuffer.
    write      = (state_reg == S_WRITE) && !abort;
    chipselect = write;
    unique case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          if (empty) begin
            state_next = S_DONE;
          end else begin
            load       = 1'b1;
            state_next = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        busy = 1'b1;
        if (abort || last) state_next = S_DONE;
        else               advance    = 1'b1;
      end
      S_DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      writedata_reg <= '0;
`ifdef CHECKER_EN
      row_start_reg <= '0;
`endif
    end else if (load) begin
      writedata_reg <= cmd_pattern;
`ifdef CHECKER_EN
      row_start_reg <= cmd_pattern;
`endif
    end
`ifdef CHECKER_EN
    else if (advance) begin
      if (row_wrap) begin
        row_start_reg <= ~row_start_reg;
        writedata_reg <= ~row_start_reg;
      end else begin
        writedata_reg <= ~writedata_reg;
      end
    end
`endif
  end

  assign writedata = writedata_reg;

endmodule
